// File: rtl/param_update_arbiter_if.sv
// Host parameter-write channel: valid/ready handshake carrying one {addr, data} write.
// The master modport is the host bridge and the slave modport is the arbiter's queue input.
interface param_update_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 36
);
  logic                  host_wr_valid;
  logic                  host_wr_ready;
  logic [ADDR_WIDTH-1:0] host_wr_addr;
  logic [DATA_WIDTH-1:0] host_wr_data;

  modport master (
    output host_wr_valid,
    output host_wr_addr,
    output host_wr_data,
    input  host_wr_ready
  );

  modport slave (
    input  host_wr_valid,
    input  host_wr_addr,
    input  host_wr_data,
    output host_wr_ready
  );
endinterface

// File: rtl/param_update_arbiter.sv
// Arbitrates the single-port parameter RAM between DSP reads and queued host writes.
// Host writes are committed only between frames, so each frame sees a coherent parameter set.
//   state | meaning
//   IDLE  | between frames, queued host writes may commit
//   RUN   | frame in progress, host writes are held in the queue
module param_update_arbiter #(
  parameter int PARAM_WIDTH      = 36,
  parameter int PARAM_ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  param_update_arbiter_if.slave         host,
  input  logic                          frame_start,
  input  logic                          frame_done,
  input  logic                          dsp_rd_en,
  input  logic [PARAM_ADDR_WIDTH-1:0]   dsp_rd_addr,
  output logic [PARAM_WIDTH-1:0]        dsp_rd_data,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [PARAM_ADDR_WIDTH-1:0]   mem_addr,
  output logic [PARAM_WIDTH-1:0]        mem_wr_data,
  input  logic [PARAM_WIDTH-1:0]        mem_rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_overrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                      state;
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [LVL_W-1:0]            count;
  logic [PARAM_ADDR_WIDTH-1:0] addr_q [FIFO_DEPTH];
  logic [PARAM_WIDTH-1:0]      data_q [FIFO_DEPTH];

  logic                        full;
  logic                        empty;
  logic                        push;
  logic                        commit;
  logic [PARAM_ADDR_WIDTH-1:0] head_addr;
  logic [PARAM_WIDTH-1:0]      head_data;

  // Full comes from the occupancy count, since wrapped pointers alone cannot tell full from empty.
  assign full  = (count == LVL_W'(FIFO_DEPTH));
  assign empty = (count == '0);

  // Ready is not allowed to rise on a same-cycle pop, so it depends only on registered occupancy.
  assign host.host_wr_ready = !full;
  assign push               = host.host_wr_valid && !full;

  // The frame_start cycle blocks commits so a new frame never sees a write landing in its first cycle.
  assign commit = (state == IDLE) && !frame_start && !empty && !dsp_rd_en;

  assign head_addr   = empty ? '0 : addr_q[rd_ptr];
  assign head_data   = empty ? '0 : data_q[rd_ptr];
  assign dsp_rd_data = mem_rd_data;
  assign fifo_level  = count;

  always_comb begin
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = head_addr;
    mem_wr_data = head_data;
    if (dsp_rd_en) begin
      mem_en   = 1'b1;
      mem_addr = dsp_rd_addr;
    end else if (commit) begin
      mem_en = 1'b1;
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= host.host_wr_addr;
      data_q[wr_ptr] <= host.host_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (commit) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Simultaneous start and done in RUN is a back-to-back frame boundary, not an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      frame_overrun <= 1'b0;
    end else begin
      frame_overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (frame_start && !frame_done) begin
            frame_overrun <= 1'b1;
          end else if (frame_done && !frame_start) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_update_arbiter.sv
// Bench for param_update_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized traffic phase.
module tb_param_update_arbiter;
  localparam int AW    = 10;
  localparam int DW    = 36;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          frame_done = 1'b0;
  logic          dsp_rd_en = 1'b0;
  logic [AW-1:0] dsp_rd_addr = '0;
  logic [DW-1:0] dsp_rd_data;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;
  logic [LW-1:0] fifo_level;
  logic          frame_overrun;

  int errors = 0;
  int checks = 0;

  param_update_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) hif ();

  param_update_arbiter #(
    .PARAM_WIDTH(DW),
    .PARAM_ADDR_WIDTH(AW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .host(hif.slave),
    .frame_start(frame_start),
    .frame_done(frame_done),
    .dsp_rd_en(dsp_rd_en),
    .dsp_rd_addr(dsp_rd_addr),
    .dsp_rd_data(dsp_rd_data),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data),
    .fifo_level(fifo_level),
    .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending writes as a queue plus an "inside a frame" flag.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t m_q[$];
  bit   m_in_frame = 1'b0;
  bit   m_ovr = 1'b0;

  function automatic bit m_commit();
    return !m_in_frame && !frame_start && (m_q.size() > 0) && !dsp_rd_en;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    bit cm;
    bit ps;
    if (reset) begin
      m_q.delete();
      m_in_frame = 1'b0;
      m_ovr      = 1'b0;
    end else begin
      cm = m_commit();
      ps = hif.host_wr_valid && (m_q.size() < DEPTH);
      if (cm) void'(m_q.pop_front());
      if (ps) m_q.push_back({hif.host_wr_addr, hif.host_wr_data});
      m_ovr = m_in_frame && frame_start && !frame_done;
      if (!m_in_frame) m_in_frame = frame_start;
      else if (frame_done && !frame_start) m_in_frame = 1'b0;
    end
  end

  always @(negedge clk) begin : cmp
    bit            cm;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    cm = m_commit();
    ea = (m_q.size() > 0) ? m_q[0].a : '0;
    ed = (m_q.size() > 0) ? m_q[0].d : '0;
    chk("host_wr_ready", 64'(hif.host_wr_ready), 64'(m_q.size() < DEPTH));
    chk("fifo_level", 64'(fifo_level), 64'(m_q.size()));
    chk("mem_en", 64'(mem_en), 64'(dsp_rd_en || cm));
    chk("mem_we", 64'(mem_we), 64'(cm));
    chk("mem_addr", 64'(mem_addr), 64'(dsp_rd_en ? dsp_rd_addr : ea));
    if (!dsp_rd_en) chk("mem_wr_data", 64'(mem_wr_data), 64'(ed));
    chk("frame_overrun", 64'(frame_overrun), 64'(m_ovr));
    chk("dsp_rd_data", 64'(dsp_rd_data), 64'(mem_rd_data));
  end

  task automatic drive(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit fs, input bit fd, input bit rd, input logic [AW-1:0] ra);
    @(posedge clk);
    #1;
    hif.host_wr_valid = v;
    hif.host_wr_addr  = a;
    hif.host_wr_data  = d;
    frame_start       = fs;
    frame_done        = fd;
    dsp_rd_en         = rd;
    dsp_rd_addr       = ra;
    mem_rd_data       = DW'({$urandom(), $urandom()});
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_wr(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk({nm, "_we"}, 64'(mem_we), 64'd1);
    chk({nm, "_addr"}, 64'(mem_addr), 64'(a));
    chk({nm, "_data"}, 64'(mem_wr_data), 64'(d));
  endtask

  initial begin
    int rd_pct;
    hif.host_wr_valid = 1'b0;
    hif.host_wr_addr  = '0;
    hif.host_wr_data  = '0;

    // Reset state
    look();
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ready", 64'(hif.host_wr_ready), 64'd1);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_overrun", 64'(frame_overrun), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // IDLE write commits the cycle after acceptance
    drive(1'b1, 10'h012, 36'h123456789, 1'b0, 1'b0, 1'b0, '0);
    look();
    chk("idle_pre_we", 64'(mem_we), 64'd0);
    idle();
    look();
    chk_wr("idle_commit", 10'h012, 36'h123456789);
    chk("idle_level1", 64'(fifo_level), 64'd1);
    idle();
    look();
    chk("idle_level0", 64'(fifo_level), 64'd0);

    // Writes queue during a frame, then drain in order after frame_done
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, AW'(i), DW'(9 + i), 1'b0, 1'b0, 1'b0, '0);
      look();
      chk("run_no_we", 64'(mem_we), 64'd0);
    end
    idle();
    look();
    chk("run_full_ready", 64'(hif.host_wr_ready), 64'd0);
    chk("run_full_level", 64'(fifo_level), 64'd4);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
    look();
    chk("done_cycle_we", 64'(mem_we), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      idle();
      look();
      chk_wr("drain", AW'(i), DW'(9 + i));
      if (i == 1) chk("drain_ready_first", 64'(hif.host_wr_ready), 64'd0);
      if (i == 2) chk("drain_ready_second", 64'(hif.host_wr_ready), 64'd1);
    end
    idle();
    look();
    chk("drain_empty", 64'(fifo_level), 64'd0);

    // DSP reads win over pending commits
    drive(1'b1, 10'h100, 36'h1, 1'b0, 1'b0, 1'b1, 10'h3FF);
    drive(1'b1, 10'h101, 36'h2, 1'b0, 1'b0, 1'b1, 10'h3FF);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 10'h3FF);
      look();
      chk("cont_we", 64'(mem_we), 64'd0);
      chk("cont_addr", 64'(mem_addr), 64'h3FF);
      chk("cont_level", 64'(fifo_level), 64'd2);
    end
    idle();
    look();
    chk_wr("cont_c0", 10'h100, 36'h1);
    idle();
    look();
    chk_wr("cont_c1", 10'h101, 36'h2);

    // frame_start preempts draining
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) drive(1'b1, AW'(10'h200 + i), DW'(36'h70 + i), 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
    idle();
    look();
    chk_wr("pre_c0", 10'h200, 36'h70);
    idle();
    look();
    chk_wr("pre_c1", 10'h201, 36'h71);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
    look();
    chk("pre_fs_we", 64'(mem_we), 64'd0);
    chk("pre_fs_level", 64'(fifo_level), 64'd2);
    idle();
    look();
    chk("pre_run_we", 64'(mem_we), 64'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
    idle();
    look();
    chk_wr("pre_c2", 10'h202, 36'h72);
    idle();
    look();
    chk_wr("pre_c3", 10'h203, 36'h73);

    // Overrun, back-to-back frames, frame_done while idle
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
    look();
    chk("ovr_same_cycle", 64'(frame_overrun), 64'd0);
    idle();
    look();
    chk("ovr_pulse", 64'(frame_overrun), 64'd1);
    drive(1'b1, 10'h300, 36'h55, 1'b0, 1'b0, 1'b0, '0);
    look();
    chk("ovr_pulse_end", 64'(frame_overrun), 64'd0);
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, '0);
    look();
    chk("b2b_we", 64'(mem_we), 64'd0);
    idle();
    look();
    chk("b2b_no_ovr", 64'(frame_overrun), 64'd0);
    chk("b2b_still_run", 64'(mem_we), 64'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
    idle();
    look();
    chk_wr("b2b_commit", 10'h300, 36'h55);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
    drive(1'b1, 10'h301, 36'h66, 1'b0, 1'b0, 1'b0, '0);
    idle();
    look();
    chk_wr("done_in_idle", 10'h301, 36'h66);

    // Asynchronous reset with writes queued
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) drive(1'b1, AW'(10'h3A0 + i), DW'(i + 1), 1'b0, 1'b0, 1'b0, '0);
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_level", 64'(fifo_level), 64'd0);
    chk("arst_ready", 64'(hif.host_wr_ready), 64'd1);
    chk("arst_we", 64'(mem_we), 64'd0);
    chk("arst_overrun", 64'(frame_overrun), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      look();
      chk("arst_no_commit", 64'(mem_en), 64'd0);
    end

    // Randomized traffic, read intensity varied per block
    for (int blk = 0; blk < 6; blk++) begin
      rd_pct = (blk % 3) * 30;
      for (int n = 0; n < 500; n++) begin
        drive($urandom_range(0, 1) == 0, AW'($urandom()), DW'({$urandom(), $urandom()}),
              $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 99) < rd_pct, AW'($urandom()));
      end
    end

    idle();
    look();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
